// File: rtl/bcd_modn_counter.sv
// bcd_modn_counter: multi-digit BCD modulo counter with up/down, checked load, and carry/borrow chaining.
// Define BCD_MODN_SATURATE_EN to pin the count at MIN_VAL/MAX_VAL instead of wrapping.
module bcd_modn_counter #(
   parameter int NDIG    = 2,
   parameter int MODULUS = 60,
   parameter int MIN_VAL = 0
) (
   input  logic            ck,
   input  logic            rst,
   input  logic            inc,
   input  logic            up_dn,
   input  logic            load,
   input  logic [4*NDIG-1:0] load_val,
   output logic [4*NDIG-1:0] count,
   output logic            carry_out,
   output logic            borrow_out,
   output logic            load_err
);
   localparam int W       = 4*NDIG;
   localparam int MAX_VAL = MIN_VAL + MODULUS - 1;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int t;
      t = v;
      r = '0;
      for (int i = 0; i < NDIG; i++) begin
         r[4*i+:4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
   localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

   logic [W-1:0]    r_count;
   logic            r_load_err;
   logic [NDIG-1:0] w_cy, w_bw, w_nib_ok;
   logic [W-1:0]    w_up, w_dn, w_wrap_up, w_wrap_dn, w_next;
   logic            w_at_max, w_at_min, w_load_ok;

   assign w_cy[0] = 1'b1;
   assign w_bw[0] = 1'b1;

   // Digit-level carry/borrow ripples within one cycle; no binary conversion.
   for (genvar d = 0; d < NDIG; d++) begin : g_dig
      assign w_up[4*d+:4] = w_cy[d] ? (r_count[4*d+:4] == 4'd9 ? 4'd0 : r_count[4*d+:4] + 4'd1)
                                    : r_count[4*d+:4];
      assign w_dn[4*d+:4] = w_bw[d] ? (r_count[4*d+:4] == 4'd0 ? 4'd9 : r_count[4*d+:4] - 4'd1)
                                    : r_count[4*d+:4];
      assign w_nib_ok[d]  = load_val[4*d+:4] <= 4'd9;
      if (d < NDIG-1) begin : g_chain
         assign w_cy[d+1] = w_cy[d] & (r_count[4*d+:4] == 4'd9);
         assign w_bw[d+1] = w_bw[d] & (r_count[4*d+:4] == 4'd0);
      end
   end

`ifdef BCD_MODN_SATURATE_EN
   assign w_wrap_up = MAX_BCD;
   assign w_wrap_dn = MIN_BCD;
`else
   assign w_wrap_up = MIN_BCD;
   assign w_wrap_dn = MAX_BCD;
`endif

   assign w_at_max  = r_count == MAX_BCD;
   assign w_at_min  = r_count == MIN_BCD;
   // With all nibbles valid, BCD vectors order the same as their decimal values.
   assign w_load_ok = (&w_nib_ok) && load_val >= MIN_BCD && load_val <= MAX_BCD;
   assign w_next    = up_dn ? (w_at_max ? w_wrap_up : w_up) : (w_at_min ? w_wrap_dn : w_dn);

   always_ff @(posedge ck) begin
      if (rst) begin
         r_count    <= MIN_BCD;
         r_load_err <= 1'b0;
      end else if (load) begin
         r_load_err <= ~w_load_ok;
         if (w_load_ok) r_count <= load_val;
      end else begin
         r_load_err <= 1'b0;
         if (inc) r_count <= w_next;
      end
   end

   assign count      = r_count;
   assign load_err   = r_load_err;
   assign carry_out  = inc & up_dn & ~load & ~rst & w_at_max;
   assign borrow_out = inc & ~up_dn & ~load & ~rst & w_at_min;
endmodule

// File: tb/tb_bcd_modn_counter.sv
// tb_bcd_modn_counter: scoreboard bench for bcd_modn_counter (mod60, 1..12, 4-digit, and a secs->mins chain).
// Honours BCD_MODN_SATURATE_EN in its reference model.
module tb_bcd_modn_counter;
`ifdef BCD_MODN_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic            sv;
      logic [4:0][15:0] cnt;
      logic [4:0]      e;
      logic [4:0]      c;
      logic [4:0]      b;
   } item_t;

   logic        ck = 1'b0;
   logic        rst;
   logic        inc [3];
   logic        up  [3];
   logic        ld  [3];
   logic [15:0] lv  [3];
   logic        inc_c, up_c, ld_c;
   logic [15:0] lv_s, lv_m;
   logic [7:0]  c0, c1, cs, cm;
   logic [15:0] c2;
   logic [4:0]  cy, bw, er;
   logic        w_cinc;
   logic [15:0] cnt_all [5];

   int    mn [5] = '{0, 1, 0, 0, 0};
   int    mx [5] = '{59, 12, 1999, 59, 59};
   int    nd [5] = '{2, 2, 4, 2, 2};
   int    mv [5];
   bit    me [5];
   bit    sv_ok = 1'b0;
   item_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   always #5 ck = ~ck;

   bcd_modn_counter #(.NDIG(2), .MODULUS(60), .MIN_VAL(0)) u0 (
      .ck(ck), .rst(rst), .inc(inc[0]), .up_dn(up[0]), .load(ld[0]), .load_val(lv[0][7:0]),
      .count(c0), .carry_out(cy[0]), .borrow_out(bw[0]), .load_err(er[0]));
   bcd_modn_counter #(.NDIG(2), .MODULUS(12), .MIN_VAL(1)) u1 (
      .ck(ck), .rst(rst), .inc(inc[1]), .up_dn(up[1]), .load(ld[1]), .load_val(lv[1][7:0]),
      .count(c1), .carry_out(cy[1]), .borrow_out(bw[1]), .load_err(er[1]));
   bcd_modn_counter #(.NDIG(4), .MODULUS(2000), .MIN_VAL(0)) u2 (
      .ck(ck), .rst(rst), .inc(inc[2]), .up_dn(up[2]), .load(ld[2]), .load_val(lv[2]),
      .count(c2), .carry_out(cy[2]), .borrow_out(bw[2]), .load_err(er[2]));
   bcd_modn_counter #(.NDIG(2), .MODULUS(60), .MIN_VAL(0)) u_sec (
      .ck(ck), .rst(rst), .inc(inc_c), .up_dn(up_c), .load(ld_c), .load_val(lv_s),
      .count(cs), .carry_out(cy[3]), .borrow_out(bw[3]), .load_err(er[3]));
   bcd_modn_counter #(.NDIG(2), .MODULUS(60), .MIN_VAL(0)) u_min (
      .ck(ck), .rst(rst), .inc(w_cinc), .up_dn(up_c), .load(ld_c), .load_val(lv_m),
      .count(cm), .carry_out(cy[4]), .borrow_out(bw[4]), .load_err(er[4]));

   assign w_cinc     = cy[3] | bw[3];
   assign cnt_all[0] = {8'h00, c0};
   assign cnt_all[1] = {8'h00, c1};
   assign cnt_all[2] = c2;
   assign cnt_all[3] = {8'h00, cs};
   assign cnt_all[4] = {8'h00, cm};

   function automatic logic [15:0] bcd(input int v);
      logic [15:0] r;
      int t;
      t = v;
      for (int j = 0; j < 4; j++) begin
         r[4*j+:4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Reference model works on decimal integers; returns {carry, borrow} for this cycle.
   function automatic logic [1:0] mstep(input int k, input logic r, i, u, l, input logic [15:0] v);
      logic c, b;
      int   dec;
      bit   ok;
      c = i & u & !l & !r & (mv[k] == mx[k]);
      b = i & !u & !l & !r & (mv[k] == mn[k]);
      if (r) begin
         mv[k] = mn[k];
         me[k] = 1'b0;
      end else if (l) begin
         ok  = 1'b1;
         dec = 0;
         for (int j = nd[k]-1; j >= 0; j--) begin
            if (v[4*j+:4] > 4'd9) ok = 1'b0;
            dec = dec*10 + int'(v[4*j+:4]);
         end
         ok = ok && dec >= mn[k] && dec <= mx[k];
         if (ok) mv[k] = dec;
         me[k] = !ok;
      end else begin
         me[k] = 1'b0;
         if (i && u)       mv[k] = (mv[k] == mx[k]) ? (SAT ? mx[k] : mn[k]) : mv[k] + 1;
         else if (i && !u) mv[k] = (mv[k] == mn[k]) ? (SAT ? mn[k] : mx[k]) : mv[k] - 1;
      end
      return {c, b};
   endfunction

   function automatic logic [15:0] rand_lv(input int k);
      if ($urandom_range(0, 1) == 1) return bcd(int'($urandom_range(0, mx[k] + 3)));
      return 16'($urandom);
   endfunction

   task automatic clr();
      for (int k = 0; k < 3; k++) begin
         inc[k] = 1'b0; up[k] = 1'b0; ld[k] = 1'b0; lv[k] = 16'h0000;
      end
      inc_c = 1'b0; up_c = 1'b0; ld_c = 1'b0; lv_s = 16'h0000; lv_m = 16'h0000;
   endtask

   task automatic set(input int k, input logic i, u, l, input logic [15:0] v);
      inc[k] = i; up[k] = u; ld[k] = l; lv[k] = v;
   endtask

   // Pushes the expectation for the current cycle, advances the model, then moves to the next cycle.
   task automatic step();
      item_t      it;
      logic [1:0] o;
      it.sv = sv_ok;
      for (int k = 0; k < 5; k++) begin
         it.cnt[k] = bcd(mv[k]);
         it.e[k]   = me[k];
      end
      for (int k = 0; k < 3; k++) begin
         o = mstep(k, rst, inc[k], up[k], ld[k], lv[k]);
         it.c[k] = o[1]; it.b[k] = o[0];
      end
      o = mstep(3, rst, inc_c, up_c, ld_c, lv_s);
      it.c[3] = o[1]; it.b[3] = o[0];
      o = mstep(4, rst, o[1] | o[0], up_c, ld_c, lv_m);
      it.c[4] = o[1]; it.b[4] = o[0];
      q.push_back(it);
      if (rst) sv_ok = 1'b1;
      @(posedge ck);
      #1;
      clr();
      rst = 1'b0;
   endtask

   task automatic chk(input string nm, input int k, input logic [15:0] act, exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, k, $time, act, exp);
      end
   endtask

   initial begin
      item_t it;
      forever begin
         @(negedge ck);
         if (q.size() != 0) begin
            it = q.pop_front();
            for (int k = 0; k < 5; k++) begin
               if (it.sv) begin
                  chk("count", k, cnt_all[k], it.cnt[k]);
                  chk("load_err", k, 16'(er[k]), 16'(it.e[k]));
               end
               chk("carry_out", k, 16'(cy[k]), 16'(it.c[k]));
               chk("borrow_out", k, 16'(bw[k]), 16'(it.b[k]));
            end
         end
      end
   end

   initial begin
      clr();
      rst = 1'b1;
      @(posedge ck);
      #1;
      step();
      repeat (61) begin set(0, 1, 1, 0, 0); step(); end
      set(0, 0, 0, 1, 16'h00); step();
      set(0, 1, 0, 0, 0);      step();
      set(0, 0, 0, 1, 16'h10); step();
      set(0, 1, 0, 0, 0);      step();
      set(0, 1, 1, 1, 16'h5A); step();
      step();
      set(0, 1, 1, 1, 16'h60); step();
      step();
      set(1, 0, 0, 1, 16'h12); step();
      set(1, 1, 1, 0, 0);      step();
      set(1, 0, 0, 1, 16'h00); step();
      step();
      set(2, 0, 0, 1, 16'h0999); step();
      set(2, 1, 1, 0, 0);        step();
      set(2, 1, 0, 0, 0);        step();
      set(2, 0, 0, 1, 16'h1999); step();
      set(2, 1, 1, 0, 0);        step();
      set(2, 1, 0, 0, 0);        step();
      ld_c = 1'b1; lv_s = 16'h59; lv_m = 16'h59; step();
      inc_c = 1'b1; up_c = 1'b1; step();
      rst = 1'b1; inc_c = 1'b1; up_c = 1'b1; set(0, 1, 1, 0, 0); step();
      step();
      set(0, 0, 0, 1, 16'h59); step();
      repeat (3) begin set(0, 1, 1, 0, 0); step(); end
      step();
      repeat (600) begin
         rst = ($urandom_range(0, 49) == 0);
         for (int k = 0; k < 3; k++) set(k, 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0, rand_lv(k));
         inc_c = $urandom_range(0, 3) != 0;
         up_c  = 1'($urandom);
         ld_c  = $urandom_range(0, 15) == 0;
         lv_s  = rand_lv(3);
         lv_m  = rand_lv(4);
         step();
      end
      step();
      @(negedge ck);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
